// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer for the 9-bit core and owner of the dat_mem port.
// The host owns dat_mem while the core is held in reset (IDLE/DONE).
// The core owns it while it runs (RUN).
// The run ends on a core halt or after MAX_CYCLES run cycles.
module run_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 40000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              host_wr_en,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdat,
    output logic [DATA_W-1:0] host_rdat,
    output logic              host_gnt,
    output logic              core_reset,
    input  logic              core_halt,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdat,
    output logic              dm_wr_en,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_dat_in,
    input  logic [DATA_W-1:0] dm_dat_out,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycles
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              timeout_q, timeout_d;
    logic              core_reset_q, core_reset_d;
    logic              host_gnt_q, host_gnt_d;
    logic              done_q, done_d;

    // Cycle counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Next-state and counter logic; registered outputs are decoded from the next state.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RST;
                    rst_cnt_d = '0;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            S_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                cycles_d = sat_inc(cycles_q);
                // A halt in the same cycle as the limit counts as a normal finish.
                if (core_halt) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                end else if (cycles_q == RUN_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        core_reset_d = (state_d != S_RUN);
        host_gnt_d   = (state_d == S_IDLE) || (state_d == S_DONE);
        done_d       = (state_d == S_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            cycles_q     <= '0;
            timeout_q    <= 1'b0;
            core_reset_q <= 1'b1;
            host_gnt_q   <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cycles_q     <= cycles_d;
            timeout_q    <= timeout_d;
            core_reset_q <= core_reset_d;
            host_gnt_q   <= host_gnt_d;
            done_q       <= done_d;
        end
    end

    // dat_mem port mux; the core path is a pure pass-through and can only write in RUN.
    always_comb begin
        if (host_gnt_q) begin
            dm_wr_en  = host_wr_en;
            dm_addr   = host_addr;
            dm_dat_in = host_wdat;
            host_rdat = dm_dat_out;
        end else begin
            dm_wr_en  = core_wr_en && (state_q == S_RUN);
            dm_addr   = core_addr;
            dm_dat_in = core_wdat;
            host_rdat = '0;
        end
    end

    assign host_gnt   = host_gnt_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a small behavioural dat_mem.
// The DUT is built with MAX_CYCLES=100 so the timeout path is reachable quickly.
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, host_wr_en, core_halt, core_wr_en;
    logic [7:0]  host_addr, host_wdat, core_addr, core_wdat;
    logic [7:0]  host_rdat, dm_addr, dm_dat_in, dm_dat_out;
    logic        host_gnt, core_reset, dm_wr_en, done, timeout;
    logic [15:0] cycles;
    logic [7:0]  mem [256];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    run_ctrl #(
        .ADDR_W(8), .DATA_W(8), .CNT_W(16), .RST_CYCLES(2), .MAX_CYCLES(100)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wdat(host_wdat),
        .host_rdat(host_rdat), .host_gnt(host_gnt), .core_reset(core_reset),
        .core_halt(core_halt), .core_wr_en(core_wr_en), .core_addr(core_addr),
        .core_wdat(core_wdat), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr),
        .dm_dat_in(dm_dat_in), .dm_dat_out(dm_dat_out), .done(done),
        .timeout(timeout), .cycles(cycles)
    );

    // dat_mem: synchronous write, combinational read.
    always @(posedge clk) begin
        if (dm_wr_en) mem[dm_addr] <= dm_dat_in;
    end
    assign dm_dat_out = mem[dm_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; host_wr_en = 1'b0; core_halt = 1'b0; core_wr_en = 1'b0;
        host_addr = 8'h00; host_wdat = 8'h00; core_addr = 8'h00; core_wdat = 8'h00;
        step(); step();
        reset = 1'b0;
        repeat (5) step();
        chk("idle_core_reset", 32'(core_reset), 1);
        chk("idle_host_gnt", 32'(host_gnt), 1);
        chk("idle_done", 32'(done), 0);
        chk("idle_cycles", 32'(cycles), 0);
        chk("idle_timeout", 32'(timeout), 0);

        // Host preload 0x5A @ 0x10
        host_wr_en = 1'b1; host_addr = 8'h10; host_wdat = 8'h5A; #1;
        chk("idle_dm_wr_en", 32'(dm_wr_en), 1);
        chk("idle_dm_addr", 32'(dm_addr), 32'h10);
        chk("idle_dm_dat_in", 32'(dm_dat_in), 32'h5A);
        step();
        host_wr_en = 1'b0; #1;
        chk("idle_host_rdat", 32'(host_rdat), 32'h5A);

        // Halt outside RUN has no effect
        core_halt = 1'b1; step(); core_halt = 1'b0; #1;
        chk("halt_idle_done", 32'(done), 0);
        chk("halt_idle_gnt", 32'(host_gnt), 1);

        // Start: two RST cycles, host writes and core writes blocked
        start = 1'b1; step(); start = 1'b0;
        host_wr_en = 1'b1; host_wdat = 8'hFF; core_wr_en = 1'b1; #1;
        chk("rst1_core_reset", 32'(core_reset), 1);
        chk("rst1_host_gnt", 32'(host_gnt), 0);
        chk("rst1_dm_wr_en", 32'(dm_wr_en), 0);
        chk("rst1_host_rdat", 32'(host_rdat), 0);
        step();
        chk("rst2_core_reset", 32'(core_reset), 1);
        step();
        core_addr = 8'h20; core_wdat = 8'h33; #1;
        chk("run_core_reset", 32'(core_reset), 0);
        chk("run_host_gnt", 32'(host_gnt), 0);
        chk("run_dm_wr_en", 32'(dm_wr_en), 1);
        chk("run_dm_addr", 32'(dm_addr), 32'h20);
        chk("run_dm_dat_in", 32'(dm_dat_in), 32'h33);
        chk("run_cycles0", 32'(cycles), 0);
        step();
        core_wr_en = 1'b0; #1;
        chk("run_cycles1", 32'(cycles), 1);
        chk("run_dm_wr_off", 32'(dm_wr_en), 0);
        repeat (35) step();
        chk("run_cycles36", 32'(cycles), 36);
        chk("run_not_done", 32'(done), 0);

        // Halt on the 37th RUN cycle
        core_halt = 1'b1; step(); core_halt = 1'b0;
        host_wr_en = 1'b0; host_addr = 8'h10; #1;
        chk("halt_done", 32'(done), 1);
        chk("halt_cycles", 32'(cycles), 37);
        chk("halt_timeout", 32'(timeout), 0);
        chk("halt_core_reset", 32'(core_reset), 1);
        chk("halt_host_gnt", 32'(host_gnt), 1);
        chk("halt_rd_10", 32'(host_rdat), 32'h5A);
        host_addr = 8'h20; #1;
        chk("halt_rd_20", 32'(host_rdat), 32'h33);
        repeat (3) step();
        chk("done_hold", 32'(done), 1);
        chk("done_cycles_frozen", 32'(cycles), 37);

        // Timeout run
        start = 1'b1; step(); start = 1'b0; #1;
        chk("to_rst_cycles", 32'(cycles), 0);
        chk("to_rst_done", 32'(done), 0);
        step(); step();
        repeat (99) step();
        chk("to_cycles99", 32'(cycles), 99);
        chk("to_not_done", 32'(done), 0);
        step();
        chk("to_done", 32'(done), 1);
        chk("to_timeout", 32'(timeout), 1);
        chk("to_cycles", 32'(cycles), 100);
        chk("to_core_reset", 32'(core_reset), 1);

        // Halt on the limiting cycle wins over timeout
        start = 1'b1; step(); start = 1'b0; #1;
        chk("lim_rst_timeout", 32'(timeout), 0);
        step(); step();
        repeat (99) step();
        core_halt = 1'b1; step(); core_halt = 1'b0; #1;
        chk("lim_done", 32'(done), 1);
        chk("lim_timeout", 32'(timeout), 0);
        chk("lim_cycles", 32'(cycles), 100);

        // Start held high from DONE; then reset on RUN cycle 20
        start = 1'b1; step();
        chk("hold_rst_done", 32'(done), 0);
        chk("hold_rst_gnt", 32'(host_gnt), 0);
        step(); step();
        chk("hold_run_core_reset", 32'(core_reset), 0);
        repeat (19) step();
        chk("hold_cycles19", 32'(cycles), 19);
        chk("hold_still_run", 32'(core_reset), 0);
        core_wr_en = 1'b1; core_addr = 8'h30; core_wdat = 8'h77; reset = 1'b1; #1;
        chk("rstrun_dm_wr_en", 32'(dm_wr_en), 1);
        step();
        reset = 1'b0; start = 1'b0; core_wr_en = 1'b0; #1;
        chk("rstrun_core_reset", 32'(core_reset), 1);
        chk("rstrun_host_gnt", 32'(host_gnt), 1);
        chk("rstrun_cycles", 32'(cycles), 0);
        chk("rstrun_done", 32'(done), 0);
        chk("rstrun_timeout", 32'(timeout), 0);
        host_addr = 8'h30; #1;
        chk("rstrun_rd_30", 32'(host_rdat), 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
